multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore FSM that sequences a multicycle MIPS datapath with shared ALU and unified memory.
- Sits between the instruction register (opcode/funct fields) and the datapath muxes, write enables and PC-update logic.
- Replaces single-cycle decode: each instruction takes 3–5 cycles.
- Also counts retired instructions and flags illegal opcodes.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
opcode  in  6  instruction[31:26] from the instruction register
funct  in  6  instruction[5:0] from the instruction register
pcwrite  out  1  unconditional PC load
pcwritecond  out  1  PC load qualified by ALU zero (branch)
iord  out  1  memory address select: 0 = PC, 1 = ALU out
memread  out  1  memory read strobe
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
regdst  out  2  00 = rt, 01 = rd, 10 = $31
memtoreg  out  2  00 = ALU out, 01 = memory data, 10 = PC
regwrite  out  1  register file write enable
alusrca  out  1  0 = PC, 1 = register A
alusrcb  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
aluop  out  2  00 = add, 01 = sub, 10 = use funct
pcsource  out  2  00 = ALU result, 01 = ALU out (branch target), 10 = jump address, 11 = register A
illegal  out  1  high while in HALT
state  out  4  current state encoding (debug)
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- State register and instr_count update only on the rising clk edge.
- When reset == 0 at an edge: state <= FETCH (0) and instr_count <= 0. Reset mid-instruction abandons that instruction with no further strobes.
- All outputs decode combinationally from state only. Any output not listed for a state is 0.
- State encodings and outputs:
  - FETCH=0: memread, irwrite, pcwrite, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - DECODE=1: alusrca=0, alusrcb=11, aluop=00 (precompute branch target).
  - MEMADR=2: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD=3: memread, iord=1.
  - MEMWB=4: regwrite, regdst=00, memtoreg=01.
  - MEMWR=5: memwrite, iord=1.
  - RTEXE=6: alusrca=1, alusrcb=00, aluop=10.
  - RTWB=7: regwrite, regdst=01, memtoreg=00.
  - BRANCH=8: alusrca=1, alusrcb=00, aluop=01, pcwritecond, pcsource=01.
  - JUMP=9: pcwrite, pcsource=10.
  - JAL=10: pcwrite, pcsource=10, regwrite, regdst=10, memtoreg=10. PC holds PC+4 since FETCH, so $31 receives the return address.
  - JR=11: pcwrite, pcsource=11.
  - ADDIEXE=12: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB=13: regwrite, regdst=00, memtoreg=00.
  - HALT=14: illegal=1, all other outputs 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE dispatch on opcode:
    - 000000 with funct 001000 -> JR; other funct -> RTEXE.
    - 100011 or 101011 -> MEMADR.
    - 000100 -> BRANCH.
    - 000010 -> JUMP.
    - 000011 -> JAL.
    - 001000 -> ADDIEXE.
    - any other opcode -> HALT.
  - MEMADR -> MEMRD if opcode = 100011, else MEMWR.
  - MEMRD -> MEMWB.
  - RTEXE -> RTWB.
  - ADDIEXE -> ADDIWB.
  - MEMWB, MEMWR, RTWB, BRANCH, JUMP, JAL, JR, ADDIWB -> FETCH.
  - HALT -> HALT; exit only by reset.
  - Unused encoding 15 -> FETCH.
- Latency in cycles, FETCH to next FETCH: lw 5; sw, R-type, addi 4; beq, j, jal, jr 3.
- opcode and funct are sampled every cycle. The IR is stable after FETCH, so no internal copy is kept.
- instr_count increments by 1 on each edge where state is a final state (MEMWB, MEMWR, RTWB, BRANCH, JUMP, JAL, JR, ADDIWB) and reset == 1.
  - Wraps modulo 2^CNT_W.
  - Not incremented in HALT.
  - Reset has priority over increment.

Optional Feature:
- Macro MC_MEM_WAIT_EN.
- When defined:
  - Adds input port mem_ready (1 bit), placed after funct.
  - FETCH, MEMRD and MEMWR hold state while mem_ready == 0. memread/memwrite/iord stay asserted during the hold.
  - irwrite and pcwrite in FETCH are gated by mem_ready, so the PC increments exactly once per fetch.
  - Each memory access adds one cycle per wait cycle.
  - The MEMWR retire count occurs only on the edge where mem_ready == 1.
- When undefined: no port; behaves as mem_ready tied 1.

Test Plan:
1. reset=0 for 2 edges while FSM in RTEXE -> state=0, instr_count=0, FETCH outputs (memread=1, irwrite=1, pcwrite=1, alusrcb=01) on the following cycle.
2. opcode=100011 -> states 0,1,2,3,4,0. memread high in states 0 and 3 only. regwrite with memtoreg=01 in state 4. instr_count 0 -> 1.
3. opcode=000000, funct=100000 -> 0,1,6,7,0 with aluop=10 in state 6 and regdst=01 in state 7. funct=001000 -> 0,1,11,0 with pcsource=11.
4. opcode=000011 -> 0,1,10,0. In state 10: pcwrite=1, pcsource=10, regwrite=1, regdst=10, memtoreg=10.
5. opcode=111111 -> 0,1,14 then stays 14 for 10 cycles. illegal=1, instr_count frozen. reset low -> FETCH.
6. MC_MEM_WAIT_EN defined: mem_ready=0 for 3 cycles in FETCH -> state stays 0, pcwrite=0. Release -> single pcwrite pulse, then DECODE. Wrap check: CNT_W=4, 16 beq instructions -> instr_count returns to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for a multicycle MIPS datapath
//
// Sequences a shared-ALU, unified-memory MIPS datapath. An instruction takes
// 3 to 5 cycles from FETCH to the next FETCH. The block also counts retired
// instructions and parks in HALT on an unknown opcode.
//
// Optional feature: define MC_MEM_WAIT_EN to add the mem_ready input. With it,
// FETCH/MEMRD/MEMWR stall while mem_ready is low.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   opcode       instruction[31:26] from the instruction register
//   funct        instruction[5:0] from the instruction register
//   mem_ready    memory handshake (only when MC_MEM_WAIT_EN is defined)
//   pcwrite      unconditional PC load
//   pcwritecond  PC load qualified by ALU zero
//   iord         memory address select (0 = PC, 1 = ALU out)
//   memread      memory read strobe
//   memwrite     memory write strobe
//   irwrite      instruction register load
//   regdst       write register select (00 rt, 01 rd, 10 $31)
//   memtoreg     write data select (00 ALU out, 01 mem data, 10 PC)
//   regwrite     register file write enable
//   alusrca      ALU A select (0 PC, 1 reg A)
//   alusrcb      ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   aluop        ALU operation (00 add, 01 sub, 10 funct)
//   pcsource     PC source (00 ALU, 01 ALU out, 10 jump, 11 reg A)
//   illegal      high while in HALT
//   state        current state encoding (debug)
//   instr_count  retired-instruction count, wraps modulo 2^CNT_W

module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
`ifdef MC_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_JAL     = 4'd10,
    S_JR      = 4'd11,
    S_ADDIEXE = 4'd12,
    S_ADDIWB  = 4'd13,
    S_HALT    = 4'd14
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t     state_q;
  state_t     state_d;
  ctrl_t      ctrl_q;
  logic       mem_rdy;
  logic       retire;

`ifdef MC_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // Control word for each state; anything not set stays 0.
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread  = 1'b1;
        c.irwrite  = 1'b1;
        c.pcwrite  = 1'b1;
        c.alusrcb  = 2'b01;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        c.alusrcb  = 2'b11;
      end
      S_MEMADR: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = 2'b10;
      end
      S_MEMRD: begin
        c.memread  = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 2'b01;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_RTEXE: begin
        c.alusrca  = 1'b1;
        c.aluop    = 2'b10;
      end
      S_RTWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 2'b01;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
      end
      S_JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the return address.
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
        c.regwrite = 1'b1;
        c.regdst   = 2'b10;
        c.memtoreg = 2'b10;
      end
      S_JR: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b11;
      end
      S_ADDIEXE: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = 2'b10;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
      end
      S_HALT: begin
        c.illegal  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn, input logic rdy);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:      n = (fn == FN_JR) ? S_JR : S_RTEXE;
          OP_LW, OP_SW:  n = S_MEMADR;
          OP_BEQ:        n = S_BRANCH;
          OP_J:          n = S_JUMP;
          OP_JAL:        n = S_JAL;
          OP_ADDI:       n = S_ADDIEXE;
          default:       n = S_HALT;
        endcase
      end
      S_MEMADR:  n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   n = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   n = rdy ? S_FETCH : S_MEMWR;
      S_RTEXE:   n = S_RTWB;
      S_ADDIEXE: n = S_ADDIWB;
      S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ADDIWB: n = S_FETCH;
      S_HALT:    n = S_HALT;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  assign state_d = next_state(state_q, opcode, funct, mem_rdy);

  // An instruction retires on the edge leaving its last state; a stalled
  // store has not completed yet.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ADDIWB: retire = 1'b1;
      S_MEMWR: retire = mem_rdy;
      default: retire = 1'b0;
    endcase
  end

  // Control outputs are registered from the next state, so they always match
  // the state register and never glitch on opcode changes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      ctrl_q      <= decode_state(S_FETCH);
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_state(state_d);
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  // The PC and IR load in FETCH only on the cycle memory returns data, so a
  // stalled fetch advances the PC exactly once.
  assign pcwrite     = ctrl_q.pcwrite & ((state_q != S_FETCH) | mem_rdy);
  assign irwrite     = ctrl_q.irwrite & mem_rdy;
  assign pcwritecond = ctrl_q.pcwritecond;
  assign iord        = ctrl_q.iord;
  assign memread     = ctrl_q.memread;
  assign memwrite    = ctrl_q.memwrite;
  assign regdst      = ctrl_q.regdst;
  assign memtoreg    = ctrl_q.memtoreg;
  assign regwrite    = ctrl_q.regwrite;
  assign alusrca     = ctrl_q.alusrca;
  assign alusrcb     = ctrl_q.alusrcb;
  assign aluop       = ctrl_q.aluop;
  assign pcsource    = ctrl_q.pcsource;
  assign illegal     = ctrl_q.illegal;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control

module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
`ifdef MC_MEM_WAIT_EN
  logic        mem_ready;
`endif

  logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite, alusrca, illegal;
  logic [1:0]  regdst, memtoreg, alusrcb, aluop, pcsource;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        w4_pcwrite, w4_pcwritecond, w4_iord, w4_memread, w4_memwrite, w4_irwrite, w4_regwrite, w4_alusrca, w4_illegal;
  logic [1:0]  w4_regdst, w4_memtoreg, w4_alusrcb, w4_aluop, w4_pcsource;
  logic [3:0]  w4_state;
  logic [3:0]  w4_instr_count;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_count;
  int exp_path[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
`ifdef MC_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
`ifdef MC_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pcwrite(w4_pcwrite), .pcwritecond(w4_pcwritecond), .iord(w4_iord), .memread(w4_memread),
    .memwrite(w4_memwrite), .irwrite(w4_irwrite), .regdst(w4_regdst), .memtoreg(w4_memtoreg),
    .regwrite(w4_regwrite), .alusrca(w4_alusrca), .alusrcb(w4_alusrcb), .aluop(w4_aluop),
    .pcsource(w4_pcsource), .illegal(w4_illegal), .state(w4_state), .instr_count(w4_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [18:0] outs  = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regdst, memtoreg,
                       regwrite, alusrca, alusrcb, aluop, pcsource, illegal};
  wire [18:0] outs4 = {w4_pcwrite, w4_pcwritecond, w4_iord, w4_memread, w4_memwrite, w4_irwrite,
                       w4_regdst, w4_memtoreg, w4_regwrite, w4_alusrca, w4_alusrcb, w4_aluop,
                       w4_pcsource, w4_illegal};

  // Reference table of control values per state.
  function automatic logic [18:0] spec_outs(input int s, input logic rdy);
    logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0, rw = 0, asa = 0, ill = 0;
    logic [1:0] rd = 0, mtr = 0, asb = 0, aop = 0, ps = 0;
    case (s)
      0:  begin pw = rdy; mr = 1; irw = rdy; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; mtr = 2'b01; end
      5:  begin mw = 1; io = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin pw = 1; ps = 2'b10; rw = 1; rd = 2'b10; mtr = 2'b10; end
      11: begin pw = 1; ps = 2'b11; end
      12: begin asa = 1; asb = 2'b10; end
      13: rw = 1;
      14: ill = 1;
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, rd, mtr, rw, asa, asb, aop, ps, ill};
  endfunction

  // Expected state walk for one instruction, by instruction class.
  task automatic build_path(input logic [5:0] op, input logic [5:0] fn);
    exp_path = {};
    case (op)
      6'b000000: exp_path = (fn == 6'b001000) ? '{0, 1, 11} : '{0, 1, 6, 7};
      6'b100011: exp_path = '{0, 1, 2, 3, 4};
      6'b101011: exp_path = '{0, 1, 2, 5};
      6'b000100: exp_path = '{0, 1, 8};
      6'b000010: exp_path = '{0, 1, 9};
      6'b000011: exp_path = '{0, 1, 10};
      6'b001000: exp_path = '{0, 1, 12, 13};
      default:   exp_path = '{0, 1, 14};
    endcase
  endtask

  // Runs one instruction starting in FETCH, checking every cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    int idx = 0;
    int guard = 0;
    logic rdy;
    logic [18:0] ex;
    build_path(op, fn);
    opcode = op;
    funct  = fn;
    while (idx < exp_path.size() && guard < 200) begin
      guard++;
      @(negedge clk);
      rdy = 1'b1;
`ifdef MC_MEM_WAIT_EN
      if (exp_path[idx] == 0 || exp_path[idx] == 3 || exp_path[idx] == 5)
        rdy = ($urandom_range(0, 3) != 0);
      mem_ready = rdy;
`endif
      #1;
      ex = spec_outs(exp_path[idx], rdy);
      total++;
      if (state !== 4'(exp_path[idx])) begin
        bad++; $display("FAIL state op=%b: got %0d want %0d", op, state, exp_path[idx]);
      end
      total++;
      if (outs !== ex) begin
        bad++; $display("FAIL outputs op=%b st=%0d: got %b want %b", op, exp_path[idx], outs, ex);
      end
      total++;
      if (outs4 !== ex) begin
        bad++; $display("FAIL outputs_w4 op=%b st=%0d: got %b want %b", op, exp_path[idx], outs4, ex);
      end
      total++;
      if (instr_count !== exp_count) begin
        bad++; $display("FAIL instr_count: got %0d want %0d", instr_count, exp_count);
      end
      total++;
      if (w4_instr_count !== exp_count[3:0]) begin
        bad++; $display("FAIL instr_count_w4: got %0d want %0d", w4_instr_count, exp_count[3:0]);
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        if (idx == exp_path.size() - 1 && exp_path[idx] != 14) exp_count = exp_count + 1;
        idx++;
      end
    end
    total++;
    if (guard >= 200) begin
      bad++; $display("FAIL timeout op=%b: got %0d steps want %0d", op, guard, exp_path.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
`ifdef MC_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    @(posedge clk);
    #1;
    exp_count = 0;
    total++;
    if (state !== 4'd0 || instr_count !== 32'd0) begin
      bad++; $display("FAIL do_reset: got st=%0d cnt=%0d want st=0 cnt=0", state, instr_count);
    end
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    opcode = 6'b000000;
    funct  = 6'b100000;
`ifdef MC_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    exp_count = 0;
    total++;
    if (state !== 4'd0 || instr_count !== 32'd0 || outs !== spec_outs(0, 1'b1)) begin
      bad++; $display("FAIL reset_state: got st=%0d cnt=%0d o=%b want st=0 cnt=0 o=%b",
                      state, instr_count, outs, spec_outs(0, 1'b1));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (state !== 4'd6) begin
      bad++; $display("FAIL reach_rtexe: got %0d want 6", state);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (state !== 4'd0 || instr_count !== 32'd0 || outs !== spec_outs(0, 1'b1)) begin
      bad++; $display("FAIL reset_mid_rtexe: got st=%0d cnt=%0d o=%b want st=0 cnt=0 o=%b",
                      state, instr_count, outs, spec_outs(0, 1'b1));
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Reset asserted while in a final state must win over the retire increment.
  task automatic test_reset_priority();
    do_reset();
    run_instr(6'b100011, 6'h00);
    opcode = 6'b000100;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (state !== 4'd8 || instr_count !== 32'd1) begin
      bad++; $display("FAIL reach_branch: got st=%0d cnt=%0d want st=8 cnt=1", state, instr_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    exp_count = 0;
    total++;
    if (state !== 4'd0 || instr_count !== exp_count) begin
      bad++; $display("FAIL reset_priority: got st=%0d cnt=%0d want st=0 cnt=0", state, instr_count);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    do_reset();
    run_instr(6'b100011, 6'h15);
    run_instr(6'b101011, 6'h00);
    run_instr(6'b000000, 6'b100000);
    run_instr(6'b000000, 6'b001000);
    run_instr(6'b000100, 6'h00);
    run_instr(6'b000010, 6'h00);
    run_instr(6'b000011, 6'h00);
    run_instr(6'b001000, 6'h3f);
  endtask

  task automatic test_halt(input int cycles);
    repeat (cycles) begin
      @(negedge clk); #1;
      total++;
      if (state !== 4'd14 || outs !== spec_outs(14, 1'b1) || instr_count !== exp_count) begin
        bad++; $display("FAIL halt_hold: got st=%0d o=%b cnt=%0d want st=14 o=%b cnt=%0d",
                        state, outs, instr_count, spec_outs(14, 1'b1), exp_count);
      end
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(6'b100011, 6'h00);
    run_instr(6'b111111, 6'h00);
    test_halt(10);
  endtask

  task automatic test_random();
    logic [5:0] legal [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b001000};
    logic [5:0] op, fn;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = legal[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      run_instr(op, fn);
      if (exp_path[exp_path.size() - 1] == 14) test_halt(3);
    end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) run_instr(6'b000100, 6'h00);
    total++;
    if (w4_instr_count !== 4'd0 || instr_count !== 32'd16) begin
      bad++; $display("FAIL wrap: got w4=%0d cnt=%0d want w4=0 cnt=16", w4_instr_count, instr_count);
    end
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    do_reset();
    opcode = 6'b000100;
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      total++;
      if (state !== 4'd0 || pcwrite !== 1'b0 || irwrite !== 1'b0 || memread !== 1'b1) begin
        bad++; $display("FAIL fetch_stall: got st=%0d pw=%b irw=%b mr=%b want 0 0 0 1",
                        state, pcwrite, irwrite, memread);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    total++;
    if (pcwrite !== 1'b1 || irwrite !== 1'b1) begin
      bad++; $display("FAIL fetch_release: got pw=%b irw=%b want 1 1", pcwrite, irwrite);
    end
    @(posedge clk); #1;
    total++;
    if (state !== 4'd1 || pcwrite !== 1'b0) begin
      bad++; $display("FAIL after_release: got st=%0d pw=%b want st=1 pw=0", state, pcwrite);
    end
    do_reset();
  endtask
`endif

  initial begin
    reset  = 1'b0;
    opcode = '0;
    funct  = '0;
    exp_count = 0;
`ifdef MC_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    test_reset();
    test_reset_priority();
    test_directed();
    test_illegal();
    test_back_to_back_wrap();
`ifdef MC_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
